// File: rtl/mtimer_pkg.sv
// Shared register map and reset constants for the RISC-V machine timer.
// Optional prescaler is enabled by defining MTIMER_PRESCALE_EN.
package mtimer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    // All-ones keeps the interrupt quiet until software programs a deadline.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        REG_MTIME_LO    = MTIME_LO,
        REG_MTIME_HI    = MTIME_HI,
        REG_MTIMECMP_LO = MTIMECMP_LO,
        REG_MTIMECMP_HI = MTIMECMP_HI
    } mtimer_reg_e;

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the core clock into mtime ticks; only instantiated when MTIMER_PRESCALE_EN is defined.
// Tick fires on the last count of each PRESCALE-cycle window; i_clear restarts the window.
module mtimer_prescaler
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    assign o_tick = (r_count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V mtime/mtimecmp slave with a registered level timer interrupt.
// Define MTIMER_PRESCALE_EN to tick mtime every PRESCALE clocks instead of every clock.
module machine_timer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned CNT_W    = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_req,
    input  logic        i_bus_we,
    input  logic [3:0]  i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_ack,
    output logic        o_timer_int
);

    logic [CNT_W-1:0] r_mtime;
    logic [CNT_W-1:0] r_mtimecmp;
    logic [31:0]      r_rdata;
    logic             r_ack;
    logic             r_int;

    logic [CNT_W-1:0] w_mtime_nxt;
    logic [CNT_W-1:0] w_mtimecmp_nxt;
    logic [31:0]      w_rd_val;
    mtimer_reg_e      w_sel;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_mtime;
    logic             w_tick;
    logic             w_unused_addr;

    assign w_sel         = mtimer_reg_e'(i_bus_addr[3:2]);
    assign w_wr          = i_bus_req & i_bus_we;
    assign w_rd          = i_bus_req & ~i_bus_we;
    assign w_wr_mtime    = w_wr & ((w_sel == REG_MTIME_LO) | (w_sel == REG_MTIME_HI));
    assign w_unused_addr = ^i_bus_addr[1:0];

`ifdef MTIMER_PRESCALE_EN
    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_wr_mtime),
        .o_tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    // A write to either mtime half replaces that cycle's tick entirely (no carry either).
    always_comb begin
        w_mtime_nxt    = r_mtime + CNT_W'(w_tick);
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr) begin
            unique case (w_sel)
                REG_MTIME_LO:    w_mtime_nxt = {r_mtime[CNT_W-1:32], i_bus_wdata};
                REG_MTIME_HI:    w_mtime_nxt = {i_bus_wdata, r_mtime[31:0]};
                REG_MTIMECMP_LO: w_mtimecmp_nxt = {r_mtimecmp[CNT_W-1:32], i_bus_wdata};
                REG_MTIMECMP_HI: w_mtimecmp_nxt = {i_bus_wdata, r_mtimecmp[31:0]};
                default:         w_mtime_nxt = r_mtime + CNT_W'(w_tick);
            endcase
        end
    end

    always_comb begin
        w_rd_val = '0;
        unique case (w_sel)
            REG_MTIME_LO:    w_rd_val = r_mtime[31:0];
            REG_MTIME_HI:    w_rd_val = r_mtime[CNT_W-1:32];
            REG_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rd_val = r_mtimecmp[CNT_W-1:32];
            default:         w_rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_ack      <= i_bus_req;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            r_int <= (w_mtime_nxt >= w_mtimecmp_nxt);
        end
    end

    assign o_bus_rdata = r_rdata;
    assign o_bus_ack   = r_ack;
    assign o_timer_int = r_int;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed table, corner sequences and random traffic
// against a closed-form model (mtime = last written value + elapsed edges / prescale).
module tb_machine_timer;

`ifdef MTIMER_PRESCALE_EN
    localparam int unsigned P = 4;
`else
    localparam int unsigned P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        tint;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_base;
    logic [63:0] m_cmp;
    logic [31:0] m_rdata;
    int unsigned anchor;
    int unsigned edge_n;

    always #5 clk = ~clk;

    machine_timer #(
        .PRESCALE (P),
        .CNT_W    (64)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bus_req   (req),
        .i_bus_we    (we),
        .i_bus_addr  (addr),
        .i_bus_wdata (wdata),
        .o_bus_rdata (rdata),
        .o_bus_ack   (ack),
        .o_timer_int (tint)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_int;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // mtime value seen just before rising edge n
    function automatic logic [63:0] mt(input int unsigned n);
        return m_base + 64'((n - anchor) / P);
    endfunction

    task automatic model_reset();
        m_base  = '0;
        m_cmp   = '1;
        m_rdata = '0;
        anchor  = 1;
        edge_n  = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic bus(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
        logic [63:0] cur;
        logic [63:0] nv;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        edge_n++;
        cur = mt(edge_n);
        if (r && !w) begin
            case (a[3:2])
                2'd0:    m_rdata = cur[31:0];
                2'd1:    m_rdata = cur[63:32];
                2'd2:    m_rdata = m_cmp[31:0];
                default: m_rdata = m_cmp[63:32];
            endcase
        end
        if (r && w) begin
            case (a[3:2])
                2'd0: begin m_base = {cur[63:32], d}; anchor = edge_n + 1; end
                2'd1: begin m_base = {d, cur[31:0]}; anchor = edge_n + 1; end
                2'd2: m_cmp[31:0]  = d;
                default: m_cmp[63:32] = d;
            endcase
        end
        #1;
        chk("ack", 64'(ack), 64'(r));
        chk("rdata", 64'(rdata), 64'(m_rdata));
        nv = mt(edge_n + 1);
        chk("timer_int", 64'(tint), 64'(nv >= m_cmp));
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_int", 64'(tint), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        logic [31:0] d;
        logic        r;
        logic        w;

        // Reset values
        do_reset(3);
        bus(1'b1, 1'b0, 4'h8, 32'h0);
        chk("rst_cmp_lo", 64'(rdata), 64'hFFFF_FFFF);
        bus(1'b1, 1'b0, 4'hC, 32'h0);
        chk("rst_cmp_hi", 64'(rdata), 64'hFFFF_FFFF);

        // Count: 10 ticks after release
        do_reset(2);
        repeat (10 * P) bus(1'b0, 1'b0, 4'h0, 32'h0);
        bus(1'b1, 1'b0, 4'h0, 32'h0);
        chk("count_10", 64'(rdata), 64'd10);

`ifndef MTIMER_PRESCALE_EN
        // Interrupt, collision and back-to-back reads with hand-computed expectations
        tbl[0]  = '{1, 1, 4'h0, 32'h10,       32'h0,        0, "wr_mtime_lo"};
        tbl[1]  = '{1, 1, 4'hC, 32'h0,        32'h0,        0, "wr_cmp_hi"};
        tbl[2]  = '{1, 1, 4'h8, 32'h14,       32'h0,        0, "wr_cmp_lo"};
        tbl[3]  = '{0, 0, 4'h0, 32'h0,        32'h0,        0, "idle_pre_int"};
        tbl[4]  = '{1, 0, 4'h0, 32'h0,        32'h13,       1, "rd_mtime_int"};
        tbl[5]  = '{1, 0, 4'h8, 32'h0,        32'h14,       1, "rd_cmp_lo"};
        tbl[6]  = '{1, 1, 4'hC, 32'hFFFFFFFF, 32'h14,       0, "clr_cmp_hi"};
        tbl[7]  = '{1, 1, 4'h8, 32'hFFFFFFFF, 32'h14,       0, "clr_cmp_lo"};
        tbl[8]  = '{1, 0, 4'hC, 32'h0,        32'hFFFFFFFF, 0, "rd_cmp_hi"};
        tbl[9]  = '{1, 1, 4'h1, 32'h100,      32'hFFFFFFFF, 0, "collide_wr"};
        tbl[10] = '{1, 0, 4'h0, 32'h0,        32'h100,      0, "collide_rd"};
        tbl[11] = '{1, 0, 4'h4, 32'h0,        32'h0,        0, "b2b_rd_hi"};
        tbl[12] = '{1, 0, 4'h8, 32'h0,        32'hFFFFFFFF, 0, "b2b_rd_cmp"};
        tbl[13] = '{0, 0, 4'h0, 32'h0,        32'hFFFFFFFF, 0, "idle_hold"};
        do_reset(2);
        for (int i = 0; i < 14; i++) begin
            bus(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk({tbl[i].name, "_ack"}, 64'(ack), 64'(tbl[i].req));
            chk({tbl[i].name, "_rdata"}, 64'(rdata), 64'(tbl[i].exp_rdata));
            chk({tbl[i].name, "_int"}, 64'(tint), 64'(tbl[i].exp_int));
        end
`endif

        // Wrap/carry across 2^64
        bus(1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF);
        bus(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFE);
        repeat (2 * P) bus(1'b0, 1'b0, 4'h0, 32'h0);
        bus(1'b1, 1'b0, 4'h4, 32'h0);
        chk("wrap_hi", 64'(rdata), 64'd0);
        bus(1'b1, 1'b0, 4'h0, 32'h0);

        // Reset while an ack is outstanding drops it asynchronously
        bus(1'b0, 1'b0, 4'h0, 32'h0);
        req  = 1'b1;
        addr = 4'h0;
        @(posedge clk);
        #1;
        chk("ack_before_rst", 64'(ack), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ack_async_clr", 64'(ack), 64'd0);
        chk("rdata_async_clr", 64'(rdata), 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus(1'b0, 1'b0, 4'h0, 32'h0);

        // Request presented during reset is never acknowledged
        req   = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("req_in_rst_ack", 64'(ack), 64'd0);
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        bus(1'b0, 1'b0, 4'h0, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       d = 32'($urandom_range(0, 60));
                1:       d = $urandom;
                2:       d = 32'h0;
                default: d = 32'hFFFF_FFFF;
            endcase
            bus(r, w, 4'($urandom_range(0, 15)), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
